fetch_decode_queue: RTL

- Instruction queue between the fetch stage and the decode stage.
- Buffers {PC, instruction} pairs from fetch in a DEPTH-entry circular FIFO.
- Presents the oldest pair to decode under a valid/ready handshake.
- Discards all buffered and in-flight entries on a redirect flush (branch/jump taken), so decode never sees wrong-path instructions.

---
 rtl/fetch_decode_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_queue
// Description : Instruction queue between the fetch and decode stages.
//               Buffers {PC, instruction} pairs in a DEPTH-entry circular
//               FIFO and presents the oldest pair to decode under a
//               valid/ready handshake. A redirect flush empties the queue so
//               decode never sees wrong-path instructions.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               f_valid/f_ready - fetch-side handshake, f_pc/f_instr data
//               d_valid/d_ready - decode-side handshake, d_pc/d_instr data
//               flush           - redirect, discards every buffered entry
//               count           - current occupancy (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_queue #(
   parameter int XLEN               = 64,
   parameter int INSTRUCTION_LENGTH = XLEN / 2,
   parameter int DEPTH              = 4,
   parameter logic [INSTRUCTION_LENGTH-1:0] NOP_INSTR = 32'h00000013
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          f_valid,
   output logic                          f_ready,
   input  logic [XLEN-1:0]               f_pc,
   input  logic [INSTRUCTION_LENGTH-1:0] f_instr,
   output logic                          d_valid,
   input  logic                          d_ready,
   output logic [XLEN-1:0]               d_pc,
   output logic [INSTRUCTION_LENGTH-1:0] d_instr,
   input  logic                          flush,
   output logic [$clog2(DEPTH):0]        count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
   localparam logic [CNT_W-1:0] c_full    = CNT_W'(DEPTH);

   // Storage is intentionally left unreset; the count gates every read.
   logic [XLEN-1:0]               r_pc_mem    [DEPTH];
   logic [INSTRUCTION_LENGTH-1:0] r_instr_mem [DEPTH];

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic                          w_push;
   logic                          w_pop;
   logic                          w_not_full;
   logic                          w_not_empty;
   logic [XLEN-1:0]               w_head_pc;
   logic [INSTRUCTION_LENGTH-1:0] w_head_instr;

   // Both handshake flags come from registered occupancy only, so there is
   // no combinational path from d_ready to f_ready. A pop from full therefore
   // cannot admit a push in the same cycle.
   assign w_not_full  = (r_count != c_full);
   assign w_not_empty = (r_count != '0);

   assign w_push = f_valid & w_not_full  & ~flush;
   assign w_pop  = w_not_empty & d_ready & ~flush;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Storage write is gated by the same push term, so a push during reset or
   // flush is harmless: the pointers are cleared and the slot is dead.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= f_pc;
         r_instr_mem[r_wr_ptr] <= f_instr;
      end
   end

   // No fall-through bypass: the head always comes from storage, which gives
   // one cycle of minimum latency and keeps f_* off the d_* timing paths.
   always_comb begin
      w_head_pc    = '0;
      w_head_instr = NOP_INSTR;
      if (w_not_empty) begin
         w_head_pc    = r_pc_mem[r_rd_ptr];
         w_head_instr = r_instr_mem[r_rd_ptr];
      end
   end

   assign f_ready = w_not_full;
   assign d_valid = w_not_empty;
   assign d_pc    = w_head_pc;
   assign d_instr = w_head_instr;
   assign count   = r_count;

endmodule
`default_nettype wire
